// File: rtl/i2c_master_sequencer.sv
// Round-robin sequencer sharing one i2c_master between NREQ single-byte requesters.
// Optional XFER watchdog enabled by defining I2C_SEQ_TIMEOUT_EN.
module i2c_master_sequencer #(
  parameter int NREQ        = 2,
  parameter int SCL_EDGES   = 18,
  parameter int STOP_HOLD   = 4,
  parameter int TIMEOUT_CYC = 4096
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NREQ-1:0]     req_valid,
  input  logic [NREQ-1:0]     req_rw,
  input  logic [7*NREQ-1:0]   req_addr,
  input  logic [8*NREQ-1:0]   req_wdata,
  output logic [NREQ-1:0]     req_ready,
  output logic [NREQ-1:0]     done,
  output logic                busy,
  output logic                timeout_err,
  output logic                m_start,
  output logic                m_stop,
  output logic                m_rw,
  output logic [6:0]          m_addr,
  output logic [7:0]          m_wdata,
  input  logic                m_scl
);

  localparam int LW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW = $clog2(SCL_EDGES + 1);
  localparam int HW = (STOP_HOLD > 1) ? $clog2(STOP_HOLD) : 1;

  typedef enum logic [1:0] {S_IDLE, S_XFER, S_STOP} state_t;

  state_t            state_q, state_d;
  logic [LW-1:0]     last_q, last_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [HW-1:0]     hold_q, hold_d;
  logic              scl_q, scl_d;
  logic [NREQ-1:0]   req_ready_q, req_ready_d;
  logic [NREQ-1:0]   done_q, done_d;
  logic              m_start_q, m_start_d;
  logic              m_stop_q, m_stop_d;
  logic              m_rw_q, m_rw_d;
  logic [6:0]        m_addr_q, m_addr_d;
  logic [7:0]        m_wdata_q, m_wdata_d;

  logic              scl_rise;
  logic              gnt_found;
  logic [LW-1:0]     gnt_idx;
  logic [NREQ-1:0]   gnt_oh;
  logic              sel_rw;
  logic [6:0]        sel_addr;
  logic [7:0]        sel_wdata;

  assign scl_rise = m_scl & ~scl_q;

  // Search offsets last+1 .. last+NREQ so the previous winner is lowest priority.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    for (int k = 1; k <= NREQ; k++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!gnt_found && req_valid[i] && ((int'(last_q) + k) % NREQ) == i) begin
          gnt_found = 1'b1;
          gnt_idx   = LW'(i);
        end
      end
    end
  end

  always_comb begin
    gnt_oh    = '0;
    sel_rw    = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (LW'(i) == gnt_idx) begin
        gnt_oh[i] = 1'b1;
        sel_rw    = req_rw[i];
        sel_addr  = req_addr[7*i +: 7];
        sel_wdata = req_wdata[8*i +: 8];
      end
    end
  end

`ifdef I2C_SEQ_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  logic [TW-1:0] tcnt_q, tcnt_d;
  logic          terr_q, terr_d;
`endif

  always_comb begin
    state_d     = state_q;
    last_d      = last_q;
    cnt_d       = cnt_q;
    hold_d      = hold_q;
    scl_d       = m_scl;
    req_ready_d = '0;
    done_d      = '0;
    m_start_d   = m_start_q;
    m_stop_d    = m_stop_q;
    m_rw_d      = m_rw_q;
    m_addr_d    = m_addr_q;
    m_wdata_d   = m_wdata_q;
`ifdef I2C_SEQ_TIMEOUT_EN
    tcnt_d      = tcnt_q;
    terr_d      = terr_q;
`endif
    case (state_q)
      S_IDLE: begin
        m_start_d = 1'b0;
        m_stop_d  = 1'b0;
        if (gnt_found) begin
          req_ready_d = gnt_oh;
          m_rw_d      = sel_rw;
          m_addr_d    = sel_addr;
          m_wdata_d   = sel_wdata;
          last_d      = gnt_idx;
          cnt_d       = '0;
          m_start_d   = 1'b1;
          state_d     = S_XFER;
`ifdef I2C_SEQ_TIMEOUT_EN
          tcnt_d      = '0;
          terr_d      = 1'b0;
`endif
        end
      end
      S_XFER: begin
        m_start_d = 1'b1;
        m_stop_d  = 1'b0;
        if (cnt_q == CW'(SCL_EDGES)) begin
          state_d   = S_STOP;
          m_start_d = 1'b0;
          m_stop_d  = 1'b1;
          hold_d    = '0;
        end else begin
          if (scl_rise) cnt_d = cnt_q + CW'(1);
`ifdef I2C_SEQ_TIMEOUT_EN
          if (tcnt_q == TW'(TIMEOUT_CYC - 1)) begin
            state_d   = S_STOP;
            m_start_d = 1'b0;
            m_stop_d  = 1'b1;
            hold_d    = '0;
            terr_d    = 1'b1;
          end else begin
            tcnt_d = tcnt_q + TW'(1);
          end
`endif
        end
      end
      S_STOP: begin
        m_start_d = 1'b0;
        m_stop_d  = 1'b1;
        if (hold_q == HW'(STOP_HOLD - 1)) begin
          m_stop_d = 1'b0;
          state_d  = S_IDLE;
          for (int i = 0; i < NREQ; i++) done_d[i] = (LW'(i) == last_q);
        end else begin
          hold_d = hold_q + HW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      last_q      <= LW'(NREQ - 1);
      cnt_q       <= '0;
      hold_q      <= '0;
      scl_q       <= 1'b1;
      req_ready_q <= '0;
      done_q      <= '0;
      m_start_q   <= 1'b0;
      m_stop_q    <= 1'b0;
      m_rw_q      <= 1'b0;
      m_addr_q    <= '0;
      m_wdata_q   <= '0;
`ifdef I2C_SEQ_TIMEOUT_EN
      tcnt_q      <= '0;
      terr_q      <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      last_q      <= last_d;
      cnt_q       <= cnt_d;
      hold_q      <= hold_d;
      scl_q       <= scl_d;
      req_ready_q <= req_ready_d;
      done_q      <= done_d;
      m_start_q   <= m_start_d;
      m_stop_q    <= m_stop_d;
      m_rw_q      <= m_rw_d;
      m_addr_q    <= m_addr_d;
      m_wdata_q   <= m_wdata_d;
`ifdef I2C_SEQ_TIMEOUT_EN
      tcnt_q      <= tcnt_d;
      terr_q      <= terr_d;
`endif
    end
  end

`ifdef I2C_SEQ_TIMEOUT_EN
  assign timeout_err = terr_q;
`else
  assign timeout_err = 1'b0;
`endif

  assign req_ready = req_ready_q;
  assign done      = done_q;
  assign busy      = (state_q != S_IDLE);
  assign m_start   = m_start_q;
  assign m_stop    = m_stop_q;
  assign m_rw      = m_rw_q;
  assign m_addr    = m_addr_q;
  assign m_wdata   = m_wdata_q;

endmodule

// File: tb/tb_i2c_master_sequencer.sv
// Directed + randomized bench for i2c_master_sequencer with a transaction-level round-robin model.
module tb_i2c_master_sequencer;
  localparam int NREQ = 2;
  localparam int SCL_EDGES = 18;
  localparam int STOP_HOLD = 4;
  localparam int TIMEOUT_CYC = 64;

  logic              clk = 1'b0;
  logic              reset;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_rw;
  logic [7*NREQ-1:0] req_addr;
  logic [8*NREQ-1:0] req_wdata;
  logic [NREQ-1:0]   req_ready, done;
  logic              busy, timeout_err, m_start, m_stop, m_rw, m_scl;
  logic [6:0]        m_addr;
  logic [7:0]        m_wdata;

  logic [6:0] a_addr [NREQ];
  logic [7:0] a_wd   [NREQ];
  logic       a_rw   [NREQ];

  int errors = 0;
  int checks = 0;
  int last_m = NREQ - 1;

  i2c_master_sequencer #(.NREQ(NREQ), .SCL_EDGES(SCL_EDGES), .STOP_HOLD(STOP_HOLD),
                         .TIMEOUT_CYC(TIMEOUT_CYC)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_rw(req_rw), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_ready(req_ready), .done(done), .busy(busy),
    .timeout_err(timeout_err), .m_start(m_start), .m_stop(m_stop), .m_rw(m_rw),
    .m_addr(m_addr), .m_wdata(m_wdata), .m_scl(m_scl));

  always #5 clk = ~clk;

  always_comb begin
    for (int i = 0; i < NREQ; i++) begin
      req_addr[7*i +: 7]  = a_addr[i];
      req_wdata[8*i +: 8] = a_wd[i];
      req_rw[i]           = a_rw[i];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic scl_pulse;
    m_scl = 1'b1; tick;
    m_scl = 1'b0; tick;
  endtask

  // Round-robin rule: first pending requester after the last winner, wrapping.
  function automatic int pick(input logic [NREQ-1:0] v, input int last);
    int vi, j;
    vi = int'(v);
    for (int k = 1; k <= NREQ; k++) begin
      j = (last + k) % NREQ;
      if (((vi >> j) % 2) == 1) return j;
    end
    return -1;
  endfunction

  task automatic do_reset;
    reset = 1'b0; req_valid = '0; m_scl = 1'b0;
    tick; tick;
    reset = 1'b1;
    last_m = NREQ - 1;
  endtask

  // One full transaction from the granting edge to the done pulse.
  task automatic txn(input bit drop, input logic [NREQ-1:0] v_stop);
    int g;
    logic [NREQ-1:0] oh;
    g = pick(req_valid, last_m);
    if (g < 0) g = 0;
    oh = NREQ'(1 << g);
    tick;
    chk("grant_ready", 32'(req_ready), 32'(oh));
    chk("grant_start", 32'(m_start), 1);
    chk("grant_busy", 32'(busy), 1);
    chk("grant_addr", 32'(m_addr), 32'(a_addr[g]));
    chk("grant_wdata", 32'(m_wdata), 32'(a_wd[g]));
    chk("grant_rw", 32'(m_rw), 32'(a_rw[g]));
    chk("grant_done_low", 32'(done), 0);
    chk("grant_terr_clr", 32'(timeout_err), 0);
    last_m = g;
    if (drop) req_valid = req_valid & ~oh;
    for (int p = 0; p < SCL_EDGES - 1; p++) scl_pulse;
    chk("xfer_ready_low", 32'(req_ready), 0);
    chk("xfer_start_held", 32'(m_start), 1);
    chk("xfer_stop_low", 32'(m_stop), 0);
    chk("xfer_addr_held", 32'(m_addr), 32'(a_addr[g]));
    scl_pulse;
    chk("stop_start_fall", 32'(m_start), 0);
    chk("stop_rise", 32'(m_stop), 1);
    req_valid = req_valid | v_stop;
    for (int h = 1; h < STOP_HOLD; h++) begin
      m_scl = 1'($urandom_range(0, 1));
      tick;
      chk("stop_hold", 32'(m_stop), 1);
      chk("stop_no_done", 32'(done), 0);
      chk("stop_no_ready", 32'(req_ready), 0);
    end
    m_scl = 1'b0;
    tick;
    chk("done_pulse", 32'(done), 32'(oh));
    chk("done_stop_fall", 32'(m_stop), 0);
    chk("done_idle", 32'(busy), 0);
    chk("done_no_ready", 32'(req_ready), 0);
  endtask

  initial begin
    int g;
    reset = 1'b0; req_valid = '0; m_scl = 1'b0;
    for (int i = 0; i < NREQ; i++) begin a_addr[i] = '0; a_wd[i] = '0; a_rw[i] = 1'b0; end
    tick; tick; tick;
    chk("rst_ready", 32'(req_ready), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_terr", 32'(timeout_err), 0);
    chk("rst_start", 32'(m_start), 0);
    chk("rst_stop", 32'(m_stop), 0);
    chk("rst_rw", 32'(m_rw), 0);
    chk("rst_addr", 32'(m_addr), 0);
    chk("rst_wdata", 32'(m_wdata), 0);

    // Basic write from requester 0 out of reset
    reset = 1'b1;
    a_addr[0] = 7'h55; a_wd[0] = 8'hAA; a_rw[0] = 1'b0;
    req_valid = 2'b01;
    txn(1'b1, '0);

    // Both valid held: strict alternation 0 then 1
    do_reset;
    a_addr[0] = 7'h12; a_wd[0] = 8'h34; a_rw[0] = 1'b0;
    a_addr[1] = 7'h6B; a_wd[1] = 8'hC9; a_rw[1] = 1'b1;
    req_valid = 2'b11;
    txn(1'b0, '0);
    txn(1'b1, '0);
    req_valid = '0;

    // SCL activity in IDLE is ignored
    for (int i = 0; i < 4; i++) begin
      m_scl = ~m_scl; tick;
      chk("idle_scl_busy", 32'(busy), 0);
      chk("idle_scl_start", 32'(m_start), 0);
    end
    m_scl = 1'b0; tick;

    // Requester 1 raises valid during requester 0's STOP; grant one cycle after done
    req_valid = 2'b01;
    txn(1'b1, 2'b10);
    txn(1'b1, '0);

    // Reset mid-transfer after 9 edges
    a_addr[0] = 7'h21; a_wd[0] = 8'h5A; a_rw[0] = 1'b0;
    req_valid = 2'b01;
    g = pick(req_valid, last_m);
    tick;
    chk("mid_ready", 32'(req_ready), 32'(NREQ'(1 << g)));
    req_valid = '0;
    for (int p = 0; p < 9; p++) scl_pulse;
    reset = 1'b0;
    tick;
    chk("mid_rst_start", 32'(m_start), 0);
    chk("mid_rst_stop", 32'(m_stop), 0);
    chk("mid_rst_busy", 32'(busy), 0);
    for (int i = 0; i < STOP_HOLD + 2; i++) begin
      if (i == 1) reset = 1'b1;
      tick;
      chk("mid_rst_no_done", 32'(done), 0);
    end
    last_m = NREQ - 1;
    a_rw[0] = 1'b1; a_addr[0] = 7'h55; a_wd[0] = 8'h0F;
    req_valid = 2'b01;
    txn(1'b1, '0);

    // Randomized requests against the round-robin model
    for (int n = 0; n < 10; n++) begin
      for (int i = 0; i < NREQ; i++) begin
        a_addr[i] = 7'($urandom); a_wd[i] = 8'($urandom); a_rw[i] = 1'($urandom);
      end
      req_valid = '0;
      for (int w = 0; w < int'($urandom_range(0, 2)); w++) tick;
      req_valid = NREQ'($urandom_range(1, (1 << NREQ) - 1));
      txn(1'($urandom_range(0, 1)), '0);
    end
    req_valid = '0;
    tick;

    // Stuck SCL: watchdog behaviour depends on build
    a_addr[0] = 7'h3C; a_wd[0] = 8'h99; a_rw[0] = 1'b0;
    m_scl = 1'b0;
    req_valid = 2'b01;
    g = pick(req_valid, last_m);
    tick;
    chk("stuck_ready", 32'(req_ready), 32'(NREQ'(1 << g)));
    last_m = g;
    req_valid = '0;
`ifdef I2C_SEQ_TIMEOUT_EN
    for (int c = 1; c < TIMEOUT_CYC; c++) begin
      tick;
      chk("to_wait_start", 32'(m_start), 1);
    end
    tick;
    chk("to_stop", 32'(m_stop), 1);
    chk("to_start_fall", 32'(m_start), 0);
    chk("to_err", 32'(timeout_err), 1);
    for (int h = 1; h < STOP_HOLD; h++) tick;
    tick;
    chk("to_done", 32'(done), 32'(NREQ'(1 << g)));
    chk("to_err_sticky", 32'(timeout_err), 1);
    req_valid = 2'b01;
    txn(1'b1, '0);
`else
    for (int c = 0; c < 1000; c++) begin
      tick;
      chk("nto_start_held", 32'(m_start), 1);
      chk("nto_err_zero", 32'(timeout_err), 0);
    end
    do_reset;
    tick;
    chk("nto_rst_busy", 32'(busy), 0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "bench watchdog expired");
  end
endmodule
